// File: rtl/bcd_lap_timer.sv
// HH:MM:SS BCD up/down timer with tick prescaler and a show-ahead lap FIFO.
// state | meaning: IDLE cleared/loadable, RUN counting, STOP paused, DONE down-count hit zero
module bcd_lap_timer #(
  parameter int TICK_DIV  = 1,
  parameter int LAP_DEPTH = 4,
  parameter int HR_WRAP   = 24,
  parameter int CW        = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          lap,
  input  logic          clr,
  input  logic          dir,
  input  logic          load,
  input  logic [23:0]   load_val,
  input  logic          lap_pop,
  output logic [23:0]   cnt_out,
  output logic [1:0]    state,
  output logic [23:0]   lap_data,
  output logic [CW-1:0] lap_count,
  output logic          lap_empty,
  output logic          lap_full,
  output logic          done,
  output logic          load_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STOP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int SW  = CW + 1;
  localparam logic [PSW-1:0] PS_LAST  = PSW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PTR_LAST = PW'(LAP_DEPTH - 1);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(LAP_DEPTH);
  localparam logic [7:0]     HR_LAST  = 8'(HR_WRAP - 1);
  localparam logic [7:0]     HR_LIM   = 8'(HR_WRAP);

  state_t          st;
  logic [23:0]     cnt_q;
  logic [PSW-1:0]  presc;
  logic            dir_q;
  logic [23:0]     fifo_mem [LAP_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;

  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic [7:0] hr_bin;
  logic [23:0] cnt_up, cnt_dn;
  logic [3:0] lh1, lh0, lm1, lm0, ls1, ls0;
  logic [7:0] ld_hr_bin;
  logic       load_ok, tick, start_ok;

  assign {h1, h0, m1, m0, s1, s0} = cnt_q;
  assign hr_bin = ({4'd0, h1} * 8'd10) + {4'd0, h0};
  assign tick   = (st == S_RUN) && (presc == PS_LAST);

  always_comb begin
    logic [3:0] u_h1, u_h0, u_m1, u_m0, u_s1, u_s0;
    u_h1 = h1; u_h0 = h0; u_m1 = m1; u_m0 = m0; u_s1 = s1; u_s0 = s0;
    if (s0 != 4'd9) u_s0 = s0 + 4'd1;
    else begin
      u_s0 = 4'd0;
      if (s1 != 4'd5) u_s1 = s1 + 4'd1;
      else begin
        u_s1 = 4'd0;
        if (m0 != 4'd9) u_m0 = m0 + 4'd1;
        else begin
          u_m0 = 4'd0;
          if (m1 != 4'd5) u_m1 = m1 + 4'd1;
          else begin
            u_m1 = 4'd0;
            // hours roll as a two-digit BCD value up to HR_WRAP-1
            if (hr_bin >= HR_LAST) begin
              u_h1 = 4'd0;
              u_h0 = 4'd0;
            end else if (h0 != 4'd9) u_h0 = h0 + 4'd1;
            else begin
              u_h0 = 4'd0;
              u_h1 = h1 + 4'd1;
            end
          end
        end
      end
    end
    cnt_up = {u_h1, u_h0, u_m1, u_m0, u_s1, u_s0};
  end

  always_comb begin
    logic [3:0] d_h1, d_h0, d_m1, d_m0, d_s1, d_s0;
    d_h1 = h1; d_h0 = h0; d_m1 = m1; d_m0 = m0; d_s1 = s1; d_s0 = s0;
    if (s0 != 4'd0) d_s0 = s0 - 4'd1;
    else begin
      d_s0 = 4'd9;
      if (s1 != 4'd0) d_s1 = s1 - 4'd1;
      else begin
        d_s1 = 4'd5;
        if (m0 != 4'd0) d_m0 = m0 - 4'd1;
        else begin
          d_m0 = 4'd9;
          if (m1 != 4'd0) d_m1 = m1 - 4'd1;
          else begin
            d_m1 = 4'd5;
            if (h0 != 4'd0) d_h0 = h0 - 4'd1;
            else begin
              d_h0 = 4'd9;
              d_h1 = h1 - 4'd1;
            end
          end
        end
      end
    end
    cnt_dn = (cnt_q == 24'h0) ? 24'h0 : {d_h1, d_h0, d_m1, d_m0, d_s1, d_s0};
  end

  assign {lh1, lh0, lm1, lm0, ls1, ls0} = load_val;
  assign ld_hr_bin = ({4'd0, lh1} * 8'd10) + {4'd0, lh0};
  assign load_ok = (ls1 <= 4'd5) && (lm1 <= 4'd5) && (ls0 <= 4'd9) && (lm0 <= 4'd9) &&
                   (lh0 <= 4'd9) && (ld_hr_bin < HR_LIM);

  // DONE can only restart after a load gave it something to count
  assign start_ok = (st == S_DONE) ? (cnt_q != 24'h0) : !(dir && (cnt_q == 24'h0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      cnt_q    <= 24'h0;
      presc    <= '0;
      dir_q    <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        st    <= S_IDLE;
        cnt_q <= 24'h0;
        presc <= '0;
      end else if (st == S_RUN) begin
        presc <= tick ? '0 : presc + PSW'(1);
        if (tick) cnt_q <= dir_q ? cnt_dn : cnt_up;
        if (tick && dir_q && (cnt_dn == 24'h0)) begin
          st   <= S_DONE;
          done <= 1'b1;
        end else if (stop) begin
          st <= S_STOP;
        end
      end else begin
        if (load) begin
          if (load_ok) begin
            cnt_q <= load_val;
            presc <= '0;
          end else begin
            load_err <= 1'b1;
          end
        end
        if (!stop && start && start_ok) begin
          st    <= S_RUN;
          dir_q <= dir;
        end
      end
    end
  end

  logic            fifo_flush, do_push, do_pop;
  logic [SW-1:0]   wr_sum;
  logic [PW-1:0]   wr_idx, rd_next;

  assign fifo_flush = clr && (st == S_IDLE);
  assign do_push    = lap && (st == S_RUN) && !fifo_flush;
  assign do_pop     = lap_pop && (count_q != '0) && !fifo_flush;
  assign wr_sum     = SW'(rd_ptr) + SW'(count_q);
  assign wr_idx     = (wr_sum >= SW'(LAP_DEPTH)) ? PW'(wr_sum - SW'(LAP_DEPTH)) : PW'(wr_sum);
  assign rd_next    = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_idx] <= cnt_q;
  end

  // a push into a full FIFO overwrites the head slot, so the head just advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (fifo_flush) begin
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (do_push && (do_pop || lap_full)) begin
      rd_ptr <= rd_next;
    end else if (do_pop) begin
      rd_ptr  <= rd_next;
      count_q <= count_q - CW'(1);
    end else if (do_push) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign cnt_out   = cnt_q;
  assign state     = st;
  assign lap_count = count_q;
  assign lap_empty = (count_q == '0);
  assign lap_full  = (count_q == DEPTH_C);
  assign lap_data  = (count_q == '0) ? 24'h0 : fifo_mem[rd_ptr];

endmodule

// File: tb/tb_bcd_lap_timer.sv
// Directed bench for bcd_lap_timer: a 24-hour and a 12-hour instance share the same stimulus.
module tb_bcd_lap_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, lap = 1'b0, clr = 1'b0, dir = 1'b0, load = 1'b0, lap_pop = 1'b0;
  logic [23:0] load_val = 24'h0;

  logic [23:0] cnt_a, data_a, cnt_b, data_b;
  logic [1:0]  st_a, st_b;
  logic [2:0]  count_a, count_b;
  logic        empty_a, full_a, done_a, lerr_a;
  logic        empty_b, full_b, done_b, lerr_b;

  int checks = 0;
  int failures = 0;

  bcd_lap_timer #(.TICK_DIV(3), .LAP_DEPTH(4), .HR_WRAP(24)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .lap(lap), .clr(clr), .dir(dir),
    .load(load), .load_val(load_val), .lap_pop(lap_pop), .cnt_out(cnt_a), .state(st_a),
    .lap_data(data_a), .lap_count(count_a), .lap_empty(empty_a), .lap_full(full_a),
    .done(done_a), .load_err(lerr_a));

  bcd_lap_timer #(.TICK_DIV(3), .LAP_DEPTH(4), .HR_WRAP(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .lap(lap), .clr(clr), .dir(dir),
    .load(load), .load_val(load_val), .lap_pop(lap_pop), .cnt_out(cnt_b), .state(st_b),
    .lap_data(data_b), .lap_count(count_b), .lap_empty(empty_b), .lap_full(full_b),
    .done(done_b), .load_err(lerr_b));

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [23:0] v);
    load_val = v; load = 1'b1; cyc(); load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk("rst_cnt", cnt_a, 24'h0);
    chk("rst_state", st_a, 2'b00);
    chk("rst_empty", empty_a, 1'b1);
    chk("rst_count", count_a, 3'd0);
    rst_n = 1'b1;
    cyc();

    // up count, pause, resume with prescaler phase kept
    pulse_start();
    chk("run_entry", st_a, 2'b01);
    chk("run_entry_cnt", cnt_a, 24'h0);
    cyc(3);
    chk("first_tick", cnt_a, 24'h000001);
    cyc(6);
    chk("third_tick", cnt_a, 24'h000003);
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_state", st_a, 2'b10);
    cyc(4);
    chk("stop_hold", cnt_a, 24'h000003);
    pulse_start();
    chk("resume_state", st_a, 2'b01);
    chk("resume_cnt", cnt_a, 24'h000003);
    cyc();
    chk("resume_phase", cnt_a, 24'h000004);
    pulse_clr();
    chk("clr_state", st_a, 2'b00);
    chk("clr_cnt", cnt_a, 24'h0);
    dir = 1'b1; pulse_start(); dir = 1'b0;
    chk("dn_zero_start_ignored", st_a, 2'b00);

    // hour wrap, 24h and 12h
    do_load(24'h235958);
    chk("load_235958", cnt_a, 24'h235958);
    chk("load_err_hr12", lerr_b, 1'b1);
    cyc();
    chk("load_err_pulse_end", lerr_b, 1'b0);
    pulse_start();
    cyc(3);
    chk("wrap_235959", cnt_a, 24'h235959);
    cyc(3);
    chk("wrap24_zero", cnt_a, 24'h000000);
    chk("wrap24_no_done", done_a, 1'b0);
    chk("wrap24_running", st_a, 2'b01);
    pulse_clr();
    do_load(24'h115959);
    pulse_start();
    cyc(3);
    chk("wrap12_zero", cnt_b, 24'h000000);
    chk("wrap12_no_done", done_b, 1'b0);
    chk("hr24_carry_12", cnt_a, 24'h120000);
    pulse_clr();

    // down count to DONE
    do_load(24'h000002);
    dir = 1'b1; pulse_start(); dir = 1'b0;
    cyc(3);
    chk("dn_one", cnt_a, 24'h000001);
    chk("dn_latched_dir", st_a, 2'b01);
    cyc(2);
    chk("dn_no_early_done", done_a, 1'b0);
    cyc();
    chk("dn_zero", cnt_a, 24'h0);
    chk("dn_state_done", st_a, 2'b11);
    chk("dn_done_pulse", done_a, 1'b1);
    cyc();
    chk("dn_done_one_cycle", done_a, 1'b0);
    cyc(6);
    chk("dn_hold_zero", cnt_a, 24'h0);
    pulse_start();
    chk("done_start_ignored", st_a, 2'b11);

    // load checks
    pulse_clr();
    pulse_start();
    do_load(24'h123456);
    chk("run_load_no_err", lerr_a, 1'b0);
    chk("run_load_ignored", cnt_a, 24'h0);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("load_stop_state", st_a, 2'b10);
    do_load(24'h010203);
    chk("stop_load_ok", cnt_a, 24'h010203);
    chk("stop_load_no_err", lerr_a, 1'b0);
    do_load(24'h006000);
    chk("bad_min_err", lerr_a, 1'b1);
    chk("bad_min_cnt", cnt_a, 24'h010203);
    cyc();
    chk("bad_min_pulse_end", lerr_a, 1'b0);
    do_load(24'h240000);
    chk("bad_hr_err", lerr_a, 1'b1);
    chk("bad_hr_cnt", cnt_a, 24'h010203);
    do_load(24'h000060);
    chk("bad_sec_err", lerr_a, 1'b1);

    // lap FIFO
    pulse_clr();
    pulse_start();
    cyc(3);
    for (int k = 0; k < 5; k++) begin
      lap = 1'b1; cyc(); lap = 1'b0;
      cyc(2);
    end
    chk("lap_cnt6", cnt_a, 24'h000006);
    chk("lap_count_full", count_a, 3'd4);
    chk("lap_full", full_a, 1'b1);
    chk("lap_head_after_drop", data_a, 24'h000002);
    lap = 1'b1; lap_pop = 1'b1; cyc(); lap = 1'b0; lap_pop = 1'b0;
    chk("pushpop_count", count_a, 3'd4);
    chk("pushpop_head", data_a, 24'h000003);
    lap_pop = 1'b1; cyc(); lap_pop = 1'b0;
    chk("pop_count", count_a, 3'd3);
    chk("pop_head", data_a, 24'h000004);
    pulse_clr();
    chk("laps_kept_state", st_a, 2'b00);
    chk("laps_kept", count_a, 3'd3);
    pulse_clr();
    chk("flush_empty", empty_a, 1'b1);
    chk("flush_data", data_a, 24'h0);
    chk("flush_count", count_a, 3'd0);

    // async reset mid-run
    do_load(24'h010203);
    pulse_start();
    lap = 1'b1; cyc(2); lap = 1'b0;
    chk("pre_rst_laps", count_a, 3'd2);
    chk("pre_rst_cnt", cnt_a, 24'h010203);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", cnt_a, 24'h0);
    chk("async_rst_state", st_a, 2'b00);
    chk("async_rst_count", count_a, 3'd0);
    chk("async_rst_empty", empty_a, 1'b1);
    chk("async_rst_data", data_a, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
